// File: rtl/rgbw_sotp_gen.sv
// Purpose: serial LED output engine; pops 32-bit pixel words and drives an SK6812/WS2812-style single-wire line.
// Latency: 4 clocks from FIFO read to buffered pixel, 1 idle clock into the first bit, then gapless pixels.
// Backpressure: reads only while the one-pixel buffer is empty; at most one FIFO read is outstanding.
module rgbw_sotp_gen #(
  parameter int T0H       = 16,
  parameter int T0L       = 74,
  parameter int T1H       = 45,
  parameter int T1L       = 45,
  parameter int STR_RST   = 7681,
  parameter int OUT_BYTES = 4,
  parameter int ORDER     = 0,
  parameter int CNT_W     = $clog2(STR_RST + 1)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        w_extract,
  input  logic        in_rd_fifo_empty,
  input  logic [31:0] in_rd_fifo_data,
  output logic        out_rd_fifo_en,
  output logic        out_sig,
  output logic        out_busy,
  output logic [15:0] out_pix_count,
  output logic        out_underrun
);

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic [7:0] w;
  } pix_t;

  typedef enum logic [1:0] {F_IDLE, F_WAIT, F_CONV} fstate_t;
  typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW, S_RST} sstate_t;

  // Reload values: a phase of N clocks counts N-1 down to 0.
  localparam logic [CNT_W-1:0] T0H_M1 = CNT_W'(T0H - 1);
  localparam logic [CNT_W-1:0] T0L_M1 = CNT_W'(T0L - 1);
  localparam logic [CNT_W-1:0] T1H_M1 = CNT_W'(T1H - 1);
  localparam logic [CNT_W-1:0] T1L_M1 = CNT_W'(T1L - 1);
  localparam logic [CNT_W-1:0] RST_M1 = CNT_W'(STR_RST - 1);
  localparam logic [5:0]       NBITS  = 6'(8 * OUT_BYTES);
  localparam bit               W_OK   = (OUT_BYTES == 4);

  // Fetch side state
  fstate_t    f_state;
  logic       conv_ph;
  logic [7:0] col_r, col_g, col_b;
  logic       ext_q;
  logic [7:0] min_q;
  logic [7:0] min_rb;
  pix_t       conv_pix;

  // One-entry prefetch buffer
  pix_t       buf_dat;
  logic       buf_is_rst;
  logic       buf_full;
  logic       buf_load;
  logic       buf_take;
  logic       word_cap;

  // Serial side state
  sstate_t        s_state;
  logic [CNT_W-1:0] cnt;
  logic [5:0]     bitcnt;
  logic [31:0]    sh;
  logic [31:0]    load_word;
  logic [CNT_W-1:0] load_cnt;
  logic [15:0]    pix_next;
  logic           pix_end;

  logic unused_fifo_bits;
  assign unused_fifo_bits = ^in_rd_fifo_data[29:24];

  // The read pulse is registered, so the FIFO word is on the bus the cycle after the pulse.
  assign word_cap = (f_state == F_WAIT) && !out_rd_fifo_en;

  // Combinational helpers for conversion, buffer handshake and shifter loading.
  always_comb begin
    min_rb = (col_r < col_b) ? col_r : col_b;

    conv_pix = '{r: col_r, g: col_g, b: col_b, w: 8'h00};
    if (ext_q) begin
      conv_pix = '{r: col_r - min_q, g: col_g - min_q, b: col_b - min_q, w: min_q};
    end

    buf_load = ((f_state == F_CONV) && conv_ph) ||
               (word_cap && in_rd_fifo_data[31] && in_rd_fifo_data[30]);

    pix_end  = (s_state == S_LOW) && (cnt == '0) && (bitcnt == 6'd1);
    buf_take = buf_full && ((s_state == S_IDLE) || pix_end);

    if (ORDER == 1) begin
      load_word = {buf_dat.g, buf_dat.r, buf_dat.b, buf_dat.w};
    end else begin
      load_word = {buf_dat.r, buf_dat.g, buf_dat.b, buf_dat.w};
    end
    load_cnt = load_word[31] ? T1H_M1 : T0H_M1;

    pix_next = (out_pix_count == 16'hFFFF) ? out_pix_count : out_pix_count + 16'd1;
  end

  // Fetch FSM: issue one read when the buffer is empty, then capture and convert the word.
  always_ff @(posedge clk) begin
    if (rst) begin
      f_state        <= F_IDLE;
      out_rd_fifo_en <= 1'b0;
      conv_ph        <= 1'b0;
    end else begin
      out_rd_fifo_en <= 1'b0;
      case (f_state)
        F_IDLE: begin
          if (!buf_full && !in_rd_fifo_empty) begin
            out_rd_fifo_en <= 1'b1;
            f_state        <= F_WAIT;
          end
        end
        F_WAIT: begin
          if (word_cap) begin
            // Invalid words are dropped; stream resets go straight into the buffer.
            if (!in_rd_fifo_data[31] || in_rd_fifo_data[30]) begin
              f_state <= F_IDLE;
            end else begin
              conv_ph <= 1'b0;
              f_state <= F_CONV;
            end
          end
        end
        F_CONV: begin
          if (!conv_ph) begin
            conv_ph <= 1'b1;
          end else begin
            conv_ph <= 1'b0;
            f_state <= F_IDLE;
          end
        end
        default: f_state <= F_IDLE;
      endcase
    end
  end

  // Fetch datapath: colour latch, white minimum and buffer contents.
  always_ff @(posedge clk) begin
    if (word_cap && in_rd_fifo_data[31] && !in_rd_fifo_data[30]) begin
      col_g <= in_rd_fifo_data[23:16];
      col_r <= in_rd_fifo_data[15:8];
      col_b <= in_rd_fifo_data[7:0];
      ext_q <= w_extract && W_OK;
    end
    if ((f_state == F_CONV) && !conv_ph) begin
      min_q <= (min_rb < col_g) ? min_rb : col_g;
    end
    if (buf_load) begin
      buf_is_rst <= (f_state == F_WAIT);
      if (f_state == F_CONV) begin
        buf_dat <= conv_pix;
      end
    end
  end

  // Buffer occupancy: filled by the fetch FSM, emptied when the serial FSM takes the entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_full <= 1'b0;
    end else if (buf_load) begin
      buf_full <= 1'b1;
    end else if (buf_take) begin
      buf_full <= 1'b0;
    end
  end

  // Serial FSM: bit timing, pixel chaining, stream reset and status.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_state       <= S_IDLE;
      out_sig       <= 1'b0;
      cnt           <= '0;
      bitcnt        <= '0;
      sh            <= '0;
      out_pix_count <= '0;
      out_underrun  <= 1'b0;
    end else begin
      out_underrun <= 1'b0;
      case (s_state)
        S_IDLE: begin
          if (buf_full) begin
            if (buf_is_rst) begin
              s_state <= S_RST;
              cnt     <= RST_M1;
            end else begin
              sh      <= load_word;
              bitcnt  <= NBITS;
              cnt     <= load_cnt;
              out_sig <= 1'b1;
              s_state <= S_HIGH;
            end
          end
        end
        S_HIGH: begin
          if (cnt == '0) begin
            out_sig <= 1'b0;
            cnt     <= sh[31] ? T1L_M1 : T0L_M1;
            s_state <= S_LOW;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_LOW: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (bitcnt != 6'd1) begin
            sh      <= {sh[30:0], 1'b0};
            bitcnt  <= bitcnt - 6'd1;
            cnt     <= sh[30] ? T1H_M1 : T0H_M1;
            out_sig <= 1'b1;
            s_state <= S_HIGH;
          end else begin
            // Last clock of a pixel: chain straight into whatever is buffered.
            out_pix_count <= pix_next;
            if (buf_full && !buf_is_rst) begin
              sh      <= load_word;
              bitcnt  <= NBITS;
              cnt     <= load_cnt;
              out_sig <= 1'b1;
              s_state <= S_HIGH;
            end else if (buf_full) begin
              cnt     <= RST_M1;
              s_state <= S_RST;
            end else begin
              s_state      <= S_IDLE;
              out_underrun <= (pix_next != 16'd0) && (f_state != F_CONV);
            end
          end
        end
        S_RST: begin
          if (cnt == '0) begin
            out_pix_count <= '0;
            s_state       <= S_IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: s_state <= S_IDLE;
      endcase
    end
  end

  assign out_busy = (s_state != S_IDLE) || buf_full;

endmodule

// File: tb/tb_rgbw_sotp_gen.sv
// Bench for rgbw_sotp_gen: two instances (RGBW/R-G-B order and RGB/G-R-B order) with short bit timings.
// Each instance is fed by a small FIFO model whose word appears the cycle after a read pulse.
// Serial output is decoded by measuring high and low widths sampled on the falling clock edge.
module tb_rgbw_sotp_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        w_extract = 1'b0;
  logic        sel = 1'b0;

  logic        empty_a, empty_b;
  logic [31:0] data_a = '0, data_b = '0;
  logic        en_a, en_b, sig_a, sig_b, busy_a, busy_b, und_a, und_b;
  logic [15:0] cnt_a, cnt_b;

  logic [31:0] mem_a [0:15];
  logic [31:0] mem_b [0:15];
  int          wp_a = 0, rp_a = 0, wp_b = 0, rp_b = 0;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          en_cnt   = 0;
  int          und_cnt  = 0;

  logic        sig, en, busy, und;
  logic [15:0] pcnt;

  always #5 clk = ~clk;

  rgbw_sotp_gen #(.T0H(2), .T0L(4), .T1H(4), .T1L(2), .STR_RST(20), .OUT_BYTES(4), .ORDER(0)) dut_a (
    .clk(clk), .rst(rst), .w_extract(w_extract),
    .in_rd_fifo_empty(empty_a), .in_rd_fifo_data(data_a),
    .out_rd_fifo_en(en_a), .out_sig(sig_a), .out_busy(busy_a),
    .out_pix_count(cnt_a), .out_underrun(und_a)
  );

  rgbw_sotp_gen #(.T0H(2), .T0L(4), .T1H(4), .T1L(2), .STR_RST(20), .OUT_BYTES(3), .ORDER(1)) dut_b (
    .clk(clk), .rst(rst), .w_extract(w_extract),
    .in_rd_fifo_empty(empty_b), .in_rd_fifo_data(data_b),
    .out_rd_fifo_en(en_b), .out_sig(sig_b), .out_busy(busy_b),
    .out_pix_count(cnt_b), .out_underrun(und_b)
  );

  assign empty_a = (wp_a == rp_a);
  assign empty_b = (wp_b == rp_b);
  assign sig  = sel ? sig_b  : sig_a;
  assign en   = sel ? en_b   : en_a;
  assign busy = sel ? busy_b : busy_a;
  assign und  = sel ? und_b  : und_a;
  assign pcnt = sel ? cnt_b  : cnt_a;

  // FIFO models: registered read data.
  always @(posedge clk) begin
    if (en_a && (wp_a != rp_a)) begin
      data_a <= mem_a[rp_a % 16];
      rp_a   <= rp_a + 1;
    end
    if (en_b && (wp_b != rp_b)) begin
      data_b <= mem_b[rp_b % 16];
      rp_b   <= rp_b + 1;
    end
  end

  // Free-running event counters for the selected instance.
  always @(posedge clk) begin
    if (en)  en_cnt  <= en_cnt + 1;
    if (und) und_cnt <= und_cnt + 1;
  end

  task automatic push(input logic [31:0] w);
    if (!sel) begin
      mem_a[wp_a % 16] = w;
      wp_a = wp_a + 1;
    end else begin
      mem_b[wp_b % 16] = w;
      wp_b = wp_b + 1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Decode n bits; returns timing error count (100 = no rising edge seen).
  task automatic rx(input int n, input bit wait_first, input bit is_last,
                    output logic [31:0] bits, output int terr);
    int h, l, guard, explow, cap;
    logic b;
    bits = '0;
    terr = 0;
    if (wait_first) begin
      guard = 0;
      while (sig !== 1'b1 && guard < 2000) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 2000) begin
        terr = 100;
        return;
      end
    end
    for (int i = 0; i < n; i++) begin
      h = 0;
      while (sig === 1'b1 && h < 10) begin
        h++;
        @(negedge clk);
      end
      if (h == 4) begin
        b = 1'b1; explow = 2;
      end else if (h == 2) begin
        b = 1'b0; explow = 4;
      end else begin
        b = 1'b0; explow = 4; terr++;
      end
      bits = {bits[30:0], b};
      cap = (is_last && i == n - 1) ? explow : 10;
      l = 0;
      while (sig === 1'b0 && l < cap) begin
        l++;
        @(negedge clk);
      end
      if (l != explow) terr++;
    end
  endtask

  task automatic test_reset();
    int base, bad;
    sel = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_checks++; if (sig_a !== 1'b0) begin n_fail++; $display("FAIL reset_sig got=%b want=0", sig_a); end
    n_checks++; if (en_a !== 1'b0) begin n_fail++; $display("FAIL reset_en got=%b want=0", en_a); end
    n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b want=0", busy_a); end
    n_checks++; if (cnt_a !== 16'd0) begin n_fail++; $display("FAIL reset_count got=%0d want=0", cnt_a); end
    n_checks++; if (und_a !== 1'b0) begin n_fail++; $display("FAIL reset_underrun got=%b want=0", und_a); end
    n_checks++; if (sig_b !== 1'b0 || busy_b !== 1'b0) begin n_fail++; $display("FAIL reset_b sig=%b busy=%b want=0,0", sig_b, busy_b); end
    @(negedge clk);
    rst = 1'b0;
    base = en_cnt;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (sig !== 1'b0 || busy !== 1'b0) bad++;
      @(negedge clk);
    end
    n_checks++; if (en_cnt - base != 0) begin n_fail++; $display("FAIL idle_reads got=%0d want=0", en_cnt - base); end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL idle_quiet bad_cycles=%0d want=0", bad); end
  endtask

  task automatic test_white_extract();
    logic [31:0] bits;
    int terr;
    sel = 1'b0;
    do_reset();
    w_extract = 1'b1;
    push(32'h80408030);
    rx(32, 1'b1, 1'b1, bits, terr);
    n_checks++; if (bits !== 32'h50100030) begin n_fail++; $display("FAIL wx_bits got=%h want=50100030", bits); end
    n_checks++; if (terr != 0) begin n_fail++; $display("FAIL wx_timing errors=%0d want=0", terr); end
    n_checks++; if (pcnt !== 16'd1) begin n_fail++; $display("FAIL wx_count got=%0d want=1", pcnt); end
  endtask

  task automatic test_passthru_order();
    logic [31:0] bits;
    int terr;
    sel = 1'b1;
    do_reset();
    w_extract = 1'b0;
    push(32'h80408030);
    rx(24, 1'b1, 1'b1, bits, terr);
    n_checks++; if (bits !== 32'h00408030) begin n_fail++; $display("FAIL pt_bits got=%h want=00408030", bits); end
    n_checks++; if (terr != 0) begin n_fail++; $display("FAIL pt_timing errors=%0d want=0", terr); end
    n_checks++; if (pcnt !== 16'd1) begin n_fail++; $display("FAIL pt_count got=%0d want=1", pcnt); end
    repeat (5) @(negedge clk);
    n_checks++; if (sig !== 1'b0) begin n_fail++; $display("FAIL pt_no_w_byte sig=%b want=0", sig); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] b0, b1, b2;
    int t0, t1, t2, ebase, ubase;
    sel = 1'b0;
    w_extract = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    push(32'h80123456);
    push(32'h80ABCDEF);
    push(32'h80FF0081);
    ebase = en_cnt;
    ubase = und_cnt;
    @(negedge clk);
    rst = 1'b0;
    rx(32, 1'b1, 1'b0, b0, t0);
    rx(32, 1'b0, 1'b0, b1, t1);
    rx(32, 1'b0, 1'b1, b2, t2);
    n_checks++; if (b0 !== 32'h34125600) begin n_fail++; $display("FAIL b2b_pix0 got=%h want=34125600", b0); end
    n_checks++; if (b1 !== 32'hCDABEF00) begin n_fail++; $display("FAIL b2b_pix1 got=%h want=cdabef00", b1); end
    n_checks++; if (b2 !== 32'h00FF8100) begin n_fail++; $display("FAIL b2b_pix2 got=%h want=00ff8100", b2); end
    n_checks++; if (t0 + t1 + t2 != 0) begin n_fail++; $display("FAIL b2b_gapless errors=%0d want=0", t0 + t1 + t2); end
    n_checks++; if (en_cnt - ebase != 3) begin n_fail++; $display("FAIL b2b_reads got=%0d want=3", en_cnt - ebase); end
    n_checks++; if (pcnt !== 16'd3) begin n_fail++; $display("FAIL b2b_count got=%0d want=3", pcnt); end
    n_checks++; if (und_cnt - ubase != 0) begin n_fail++; $display("FAIL b2b_underrun got=%0d want=0", und_cnt - ubase); end
  endtask

  task automatic test_stream_reset();
    logic [31:0] bits;
    int terr, bad, ebase;
    sel = 1'b0;
    do_reset();
    w_extract = 1'b0;
    ebase = en_cnt;
    push(32'h80408030);
    push(32'h00123456);
    push(32'hC0000000);
    rx(32, 1'b1, 1'b1, bits, terr);
    n_checks++; if (bits !== 32'h80403000) begin n_fail++; $display("FAIL sr_bits got=%h want=80403000", bits); end
    n_checks++; if (terr != 0) begin n_fail++; $display("FAIL sr_timing errors=%0d want=0", terr); end
    n_checks++; if (pcnt !== 16'd1) begin n_fail++; $display("FAIL sr_count_before got=%0d want=1", pcnt); end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (sig !== 1'b0 || busy !== 1'b1) bad++;
      @(negedge clk);
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL sr_low_window bad_cycles=%0d want=0", bad); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL sr_busy_after got=%b want=0", busy); end
    n_checks++; if (pcnt !== 16'd0) begin n_fail++; $display("FAIL sr_count_after got=%0d want=0", pcnt); end
    n_checks++; if (en_cnt - ebase != 3) begin n_fail++; $display("FAIL sr_reads got=%0d want=3", en_cnt - ebase); end
  endtask

  task automatic test_underrun();
    logic [31:0] bits;
    int terr, ubase, bad;
    sel = 1'b0;
    do_reset();
    w_extract = 1'b0;
    ubase = und_cnt;
    push(32'h80010203);
    rx(32, 1'b1, 1'b1, bits, terr);
    n_checks++; if (bits !== 32'h02010300 || terr != 0) begin n_fail++; $display("FAIL ur_bits got=%h err=%0d want=02010300 err=0", bits, terr); end
    n_checks++; if (und !== 1'b1) begin n_fail++; $display("FAIL ur_pulse got=%b want=1", und); end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (sig !== 1'b0) bad++;
      @(negedge clk);
    end
    n_checks++; if (und_cnt - ubase != 1) begin n_fail++; $display("FAIL ur_count got=%0d want=1", und_cnt - ubase); end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL ur_sig_low bad_cycles=%0d want=0", bad); end
  endtask

  task automatic test_mid_reset();
    logic [31:0] bits;
    int terr, bad;
    sel = 1'b0;
    do_reset();
    w_extract = 1'b0;
    push(32'h80FFFFFF);
    rx(4, 1'b1, 1'b0, bits, terr);
    n_checks++; if (bits !== 32'h0000000F || terr != 0 || sig !== 1'b1) begin n_fail++; $display("FAIL mr_prefix got=%h err=%0d sig=%b want=f 0 1", bits, terr, sig); end
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_checks++; if (sig !== 1'b0) begin n_fail++; $display("FAIL mr_sig got=%b want=0", sig); end
    n_checks++; if (busy !== 1'b0 || pcnt !== 16'd0) begin n_fail++; $display("FAIL mr_state busy=%b count=%0d want=0,0", busy, pcnt); end
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      if (sig !== 1'b0 || busy !== 1'b0) bad++;
      @(negedge clk);
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL mr_idle bad_cycles=%0d want=0", bad); end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_white_extract();
    test_passthru_order();
    test_back_to_back();
    test_stream_reset();
    test_underrun();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
